// File: rtl/tm1638_pkg.sv
// Shared TM1638 link definitions: command classes, command bit positions and
// the slave-side link FSM states.
package tm1638_pkg;

  localparam logic [1:0] C_CMD_DATA = 2'b01;
  localparam logic [1:0] C_CMD_DISP = 2'b10;
  localparam logic [1:0] C_CMD_ADDR = 2'b11;

  localparam int unsigned C_BIT_RD      = 1;
  localparam int unsigned C_BIT_FIX     = 2;
  localparam int unsigned C_BIT_DISP_ON = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_IGN
  } state_e;

endpackage

// File: rtl/tm1638_in_sync.sv
// Multi-flop synchronizer for one asynchronous link pin followed by a
// rise/fall detector on the synchronized level.
module tm1638_in_sync #(
  parameter int unsigned C_SYNC_N = 2
) (
  input  logic CK_i,
  input  logic D_i,
  output logic Q_o,
  output logic RISE_o,
  output logic FALL_o
);

  logic [C_SYNC_N-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;

  // No reset: the chain keeps tracking the pin through reset so that a link
  // held mid-frame does not produce a fake edge once reset is released.
  always_comb begin
    sync_d = {sync_q[C_SYNC_N-2:0], D_i};
    prev_d = sync_q[C_SYNC_N-1];
  end

  always_ff @(posedge CK_i) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign Q_o    = sync_q[C_SYNC_N-1];
  assign RISE_o = sync_q[C_SYNC_N-1] & ~prev_q;
  assign FALL_o = ~sync_q[C_SYNC_N-1] & prev_q;

endmodule

// File: rtl/tm1638_slave_emu.sv
// TM1638 chip-side emulator: decodes STB/CLK/DIO frames into a 16x8 display
// RAM and display-control state, and shifts out key-scan bytes on reads.
module tm1638_slave_emu
  import tm1638_pkg::*;
#(
  parameter int unsigned C_SYNC_N = 2
) (
  input  logic        CK_i,
  input  logic        RST_i,
  input  logic        SCLK_i,
  input  logic        SS_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  output logic        MISO_OE_o,
  input  logic [31:0] KEY_BYTES_i,
  input  logic [3:0]  RAM_RADR_i,
  output logic [7:0]  RAM_RDAT_o,
  output logic        DISP_ON_o,
  output logic [2:0]  BRIGHT_o,
  output logic        FRAME_o,
  output logic        PROTO_ERR_o
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  tm1638_in_sync #(.C_SYNC_N(C_SYNC_N)) u_sync_sclk (
    .CK_i(CK_i), .D_i(SCLK_i), .Q_o(sclk_s), .RISE_o(sclk_rise), .FALL_o(sclk_fall)
  );
  tm1638_in_sync #(.C_SYNC_N(C_SYNC_N)) u_sync_ss (
    .CK_i(CK_i), .D_i(SS_i), .Q_o(ss_s), .RISE_o(ss_rise), .FALL_o(ss_fall)
  );
  tm1638_in_sync #(.C_SYNC_N(C_SYNC_N)) u_sync_mosi (
    .CK_i(CK_i), .D_i(MOSI_i), .Q_o(mosi_s), .RISE_o(mosi_rise), .FALL_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, ss_s, mosi_rise, mosi_fall};

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rd_q, rd_d, fix_q, fix_d;
  logic [3:0]  addr_q, addr_d;
  logic        disp_on_q, disp_on_d;
  logic [2:0]  bright_q, bright_d;
  logic        miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic        frame_q, frame_d, perr_q, perr_d;
  logic [31:0] key_q, key_d;
  logic        adv_q, adv_d;
  logic [7:0]  ram_q [16];
  logic [7:0]  rdat_q;
  logic        we;
  logic [7:0]  byte_w;
  logic        byte_done;

  assign byte_w    = {mosi_s, shift_q};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    fix_d     = fix_q;
    addr_d    = addr_q;
    disp_on_d = disp_on_q;
    bright_d  = bright_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    key_d     = key_q;
    adv_d     = adv_q;
    frame_d   = 1'b0;
    perr_d    = 1'b0;
    we        = 1'b0;

    if (ss_rise) begin
      state_d   = ST_IDLE;
      miso_oe_d = 1'b0;
      miso_d    = 1'b0;
      frame_d   = 1'b1;
      perr_d    = (bit_cnt_q != 3'd0);
      bit_cnt_d = 3'd0;
    end else if (ss_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = byte_w[7:1];
      end
      case (state_q)
        ST_CMD: begin
          if (byte_done) begin
            case (byte_w[7:6])
              C_CMD_DATA: begin
                rd_d  = byte_w[C_BIT_RD];
                fix_d = byte_w[C_BIT_FIX];
                if (byte_w[C_BIT_RD]) begin
                  key_d     = KEY_BYTES_i;
                  miso_d    = KEY_BYTES_i[0];
                  miso_oe_d = 1'b1;
                  adv_d     = 1'b0;
                  state_d   = ST_RD;
                end else begin
                  state_d = ST_IGN;
                end
              end
              C_CMD_DISP: begin
                disp_on_d = byte_w[C_BIT_DISP_ON];
                bright_d  = byte_w[2:0];
                state_d   = ST_IGN;
              end
              C_CMD_ADDR: begin
                addr_d = byte_w[3:0];
                if (rd_q) begin
                  perr_d  = 1'b1;
                  state_d = ST_IGN;
                end else begin
                  state_d = ST_WR;
                end
              end
              default: begin
                perr_d  = 1'b1;
                state_d = ST_IGN;
              end
            endcase
          end
        end
        ST_WR: begin
          if (byte_done) begin
            we = 1'b1;
            if (!fix_q) addr_d = addr_q + 4'd1;
          end
        end
        ST_RD: begin
          // A fall only advances once the master has sampled on a rise, so
          // the fall that opens the first read bit keeps key bit 0 on the pin.
          if (sclk_rise) begin
            adv_d = 1'b1;
          end else if (sclk_fall && adv_q) begin
            key_d  = {1'b0, key_q[31:1]};
            miso_d = key_q[1];
            adv_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rd_q      <= 1'b0;
      fix_q     <= 1'b0;
      addr_q    <= '0;
      disp_on_q <= 1'b0;
      bright_q  <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      frame_q   <= 1'b0;
      perr_q    <= 1'b0;
      key_q     <= '0;
      adv_q     <= 1'b0;
      ram_q     <= '{default: '0};
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      fix_q     <= fix_d;
      addr_q    <= addr_d;
      disp_on_q <= disp_on_d;
      bright_q  <= bright_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      frame_q   <= frame_d;
      perr_q    <= perr_d;
      key_q     <= key_d;
      adv_q     <= adv_d;
      if (we) ram_q[addr_q] <= byte_w;
      rdat_q    <= ram_q[RAM_RADR_i];
    end
  end

  assign MISO_o      = miso_q;
  assign MISO_OE_o   = miso_oe_q;
  assign RAM_RDAT_o  = rdat_q;
  assign DISP_ON_o   = disp_on_q;
  assign BRIGHT_o    = bright_q;
  assign FRAME_o     = frame_q;
  assign PROTO_ERR_o = perr_q;

endmodule

// File: tb/tb_tm1638_slave_emu.sv
// Bench for tm1638_slave_emu: bit-banged master frames, directed and random,
// checked against a frame-level model of the TM1638 command set.
module tb_tm1638_slave_emu;

  localparam int PH = 8;

  logic        CK_i = 1'b0;
  logic        RST_i = 1'b1;
  logic        SCLK_i = 1'b1;
  logic        SS_i = 1'b1;
  logic        MOSI_i = 1'b1;
  logic        MISO_o, MISO_OE_o;
  logic [31:0] KEY_BYTES_i = '0;
  logic [3:0]  RAM_RADR_i = '0;
  logic [7:0]  RAM_RDAT_o;
  logic        DISP_ON_o;
  logic [2:0]  BRIGHT_o;
  logic        FRAME_o, PROTO_ERR_o;

  always #5 CK_i = ~CK_i;

  tm1638_slave_emu #(.C_SYNC_N(2)) dut (
    .CK_i(CK_i), .RST_i(RST_i), .SCLK_i(SCLK_i), .SS_i(SS_i), .MOSI_i(MOSI_i),
    .MISO_o(MISO_o), .MISO_OE_o(MISO_OE_o), .KEY_BYTES_i(KEY_BYTES_i),
    .RAM_RADR_i(RAM_RADR_i), .RAM_RDAT_o(RAM_RDAT_o), .DISP_ON_o(DISP_ON_o),
    .BRIGHT_o(BRIGHT_o), .FRAME_o(FRAME_o), .PROTO_ERR_o(PROTO_ERR_o)
  );

  int checks = 0;
  int failures = 0;
  int frame_cnt = 0;
  int perr_cnt = 0;

  always @(posedge CK_i) begin
    if (FRAME_o === 1'b1) frame_cnt++;
    if (PROTO_ERR_o === 1'b1) perr_cnt++;
  end

  // reference model state
  logic [7:0] m_ram [16];
  logic       m_disp, m_rd, m_fix;
  logic [2:0] m_bright;
  logic [3:0] m_addr;
  int         m_frames = 0;
  int         m_perr = 0;

  logic [7:0] fb [24];
  int         fn;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CK_i);
  endtask

  task automatic send_bit(input logic b);
    SCLK_i = 1'b0;
    MOSI_i = b;
    wait_cyc(PH);
    SCLK_i = 1'b1;
    wait_cyc(PH);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic ss_low();
    SS_i = 1'b0;
    wait_cyc(PH);
  endtask

  task automatic ss_high();
    SS_i = 1'b1;
    wait_cyc(PH + 4);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_disp = 1'b0; m_bright = 3'd0; m_rd = 1'b0; m_fix = 1'b0; m_addr = 4'd0;
  endtask

  // Write-direction frame of fn bytes from fb[], plus trailing partial bits.
  task automatic do_frame(input int partial);
    logic [7:0] c;
    ss_low();
    for (int i = 0; i < fn; i++) send_byte(fb[i]);
    for (int k = 0; k < partial; k++) send_bit(1'($urandom_range(0, 1)));
    ss_high();
    m_frames++;
    if (partial != 0) m_perr++;
    if (fn > 0) begin
      c = fb[0];
      case (c[7:6])
        2'b01: begin m_rd = c[1]; m_fix = c[2]; end
        2'b10: begin m_disp = c[3]; m_bright = c[2:0]; end
        2'b11: begin
          m_addr = c[3:0];
          if (m_rd) m_perr++;
          else for (int i = 1; i < fn; i++) begin
            m_ram[m_addr] = fb[i];
            if (!m_fix) m_addr = m_addr + 4'd1;
          end
        end
        default: m_perr++;
      endcase
    end
  endtask

  task automatic frame1(input logic [7:0] b0);
    fb[0] = b0; fn = 1; do_frame(0);
  endtask

  // Key-scan read: command byte then ncyc master clock cycles, sampling on rise.
  task automatic read_frame(input logic [7:0] c, input int ncyc, input logic [31:0] keys);
    logic [63:0] cap, stream, mask;
    int oe_low;
    KEY_BYTES_i = keys;
    cap = '0; oe_low = 0;
    ss_low();
    send_byte(c);
    check_val("rd_oe_on", MISO_OE_o, 1);
    for (int i = 0; i < ncyc; i++) begin
      SCLK_i = 1'b0;
      MOSI_i = 1'($urandom_range(0, 1));
      wait_cyc(PH);
      cap[i] = MISO_o;
      if (MISO_OE_o !== 1'b1) oe_low++;
      SCLK_i = 1'b1;
      wait_cyc(PH);
    end
    ss_high();
    stream = {32'h0, keys};
    mask = (ncyc >= 64) ? '1 : ((64'h1 << ncyc) - 64'h1);
    check_val("rd_data", cap, stream & mask);
    check_val("rd_oe_low_count", oe_low, 0);
    check_val("rd_oe_off", MISO_OE_o, 0);
    m_frames++;
    m_rd = c[1]; m_fix = c[2];
    if ((ncyc % 8) != 0) m_perr++;
  endtask

  task automatic check_ram();
    for (int i = 0; i < 16; i++) begin
      RAM_RADR_i = 4'(i);
      wait_cyc(1);
      check_val($sformatf("ram%0d", i), RAM_RDAT_o, m_ram[i]);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_disp"}, DISP_ON_o, m_disp);
    check_val({tag, "_bright"}, BRIGHT_o, m_bright);
    check_val({tag, "_frames"}, frame_cnt, m_frames);
    check_val({tag, "_perr"}, perr_cnt, m_perr);
  endtask

  initial begin
    model_reset();
    wait_cyc(8);
    RST_i = 1'b0;
    wait_cyc(4);
    check_val("rst_oe", MISO_OE_o, 0);
    check_val("rst_miso", MISO_o, 0);
    check_val("rst_rdat", RAM_RDAT_o, 0);
    check_val("rst_frame", FRAME_o, 0);
    check_val("rst_perr", PROTO_ERR_o, 0);
    check_status("rst");

    // sequential fill of the whole RAM
    frame1(8'h40);
    fb[0] = 8'hC0;
    for (int i = 0; i < 16; i++) fb[i+1] = 8'(i);
    fn = 17; do_frame(0);
    check_ram();
    check_status("fill");

    // fixed address, then wrap from 15 to 0
    frame1(8'h44);
    fb[0] = 8'hC5; fb[1] = 8'hAA; fn = 2; do_frame(0);
    fb[0] = 8'hC5; fb[1] = 8'h55; fn = 2; do_frame(0);
    frame1(8'h40);
    fb[0] = 8'hCF; fb[1] = 8'h11; fb[2] = 8'h22; fn = 3; do_frame(0);
    check_ram();
    check_status("fixwrap");

    frame1(8'h8C);
    check_val("disp_on_8c", DISP_ON_o, 1);
    check_val("bright_8c", BRIGHT_o, 4);
    frame1(8'h80);
    check_status("disp80");

    read_frame(8'h42, 40, 32'h0411_0081);
    check_status("read");

    // partial data byte, then a class-00 command, then an address set while rd=1
    frame1(8'h40);
    fb[0] = 8'hC3; fn = 1; do_frame(5);
    frame1(8'h00);
    check_ram();
    check_status("errs");
    read_frame(8'h42, 8, 32'h1234_5678);
    fb[0] = 8'hC2; fb[1] = 8'h99; fn = 2; do_frame(0);
    check_ram();
    check_status("addr_in_rd");

    // reset in the middle of a key read
    frame1(8'h8F);
    KEY_BYTES_i = 32'hFFFF_FFFF;
    ss_low();
    send_byte(8'h42);
    send_bit(1'b0);
    RST_i = 1'b1;
    wait_cyc(1);
    check_val("mid_rst_oe", MISO_OE_o, 0);
    check_val("mid_rst_miso", MISO_o, 0);
    check_val("mid_rst_disp", DISP_ON_o, 0);
    check_val("mid_rst_bright", BRIGHT_o, 0);
    check_val("mid_rst_rdat", RAM_RDAT_o, 0);
    RST_i = 1'b0;
    model_reset();
    frame_cnt = m_frames; perr_cnt = m_perr;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check_val("post_rst_oe", MISO_OE_o, 0);
    ss_high();
    m_frames++;
    check_ram();
    check_status("mid_rst");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0: frame1(8'h40 | (8'($urandom) & 8'h3D));
        1: begin
          fb[0] = 8'hC0 | (8'($urandom) & 8'h3F);
          fn = 1 + $urandom_range(0, 5);
          for (int i = 1; i < fn; i++) fb[i] = 8'($urandom);
          do_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end
        2: frame1(8'h80 | (8'($urandom) & 8'h3F));
        3: read_frame(8'h42 | (8'($urandom) & 8'h3D),
                      ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(0, 5) : $urandom_range(1, 40),
                      $urandom);
        4: begin
          fb[0] = 8'($urandom) & 8'h3F; fb[1] = 8'($urandom);
          fn = $urandom_range(1, 2); do_frame(0);
        end
        default: begin fn = 0; do_frame($urandom_range(1, 7)); end
      endcase
      check_status($sformatf("rnd%0d", it));
      if ((it % 6) == 5) check_ram();
    end
    check_ram();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
